// File: rtl/fabric_clk_div.sv
// fabric_clk_div: glitch-free programmable integer clock divider with boundary-aligned
// ratio changes and graceful stop; O is registered for the global clock buffer.
module fabric_clk_div #(
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 C,
    input  logic                 R,
    input  logic                 EN,
    input  logic [DIV_WIDTH-1:0] DIV,
    input  logic                 LOAD,
    output logic                 BUSY,
    output logic                 ACTIVE,
    output logic                 O
);
    localparam logic [DIV_WIDTH-1:0] DEF_N = (DEFAULT_DIV < 2) ? DIV_WIDTH'(2) : DIV_WIDTH'(DEFAULT_DIV);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_ratio;
    logic [DIV_WIDTH-1:0] r_pend;
    logic                 r_busy;
    logic                 r_o;

    state_t               w_state_nxt;
    logic [DIV_WIDTH-1:0] w_cnt_nxt;
    logic [DIV_WIDTH-1:0] w_ratio_nxt;
    logic [DIV_WIDTH-1:0] w_pend_nxt;
    logic [DIV_WIDTH-1:0] w_div_c;
    logic                 w_busy_nxt;
    logic                 w_o_nxt;
    logic                 w_wrap;
    logic                 w_bound;

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ratio <= DEF_N;
            r_pend  <= '0;
            r_busy  <= 1'b0;
            r_o     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ratio <= w_ratio_nxt;
            r_pend  <= w_pend_nxt;
            r_busy  <= w_busy_nxt;
            r_o     <= w_o_nxt;
        end
    end

    // Ratio updates only happen in IDLE or on the wrap edge, so no phase is ever shortened.
    always_comb begin
        w_div_c     = (DIV < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : DIV;
        w_wrap      = (r_state != IDLE) && (r_cnt == r_ratio - DIV_WIDTH'(1));
        w_bound     = (r_state == IDLE) || w_wrap;
        w_state_nxt = (r_state == IDLE) ? (EN ? RUN : IDLE) :
                      (r_state == RUN)  ? (EN ? RUN : STOP) :
                      (EN ? RUN : (w_wrap ? IDLE : STOP));
        w_ratio_nxt = !w_bound ? r_ratio : LOAD ? w_div_c : r_busy ? r_pend : r_ratio;
        w_busy_nxt  = !w_bound && (LOAD || r_busy);
        w_pend_nxt  = LOAD ? w_div_c : r_pend;
        w_cnt_nxt   = w_bound ? '0 : r_cnt + DIV_WIDTH'(1);
        w_o_nxt     = (w_state_nxt != IDLE) && (w_cnt_nxt < (w_ratio_nxt >> 1));
    end

    always_comb begin
        ACTIVE = (r_state != IDLE);
        BUSY   = r_busy;
        O      = r_o;
    end
endmodule

// File: tb/tb_fabric_clk_div.sv
// tb_fabric_clk_div: directed plus randomized checks of fabric_clk_div against a
// period/phase-position reference model.
module tb_fabric_clk_div;
    logic       C = 1'b0;
    logic       R = 1'b0;
    logic       EN = 1'b0;
    logic       LOAD = 1'b0;
    logic [7:0] DIV = '0;
    logic       BUSY, ACTIVE, O;

    int n_chk = 0;
    int n_fail = 0;

    int m_n, m_pend, m_pos;
    bit m_on, m_stop;

    always #5 C = ~C;

    fabric_clk_div #(.DIV_WIDTH(8), .DEFAULT_DIV(2)) dut (
        .C(C), .R(R), .EN(EN), .DIV(DIV), .LOAD(LOAD),
        .BUSY(BUSY), .ACTIVE(ACTIVE), .O(O)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampn(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_reset();
        m_n = 2; m_pend = -1; m_pos = 0; m_on = 0; m_stop = 0;
    endtask

    // Period-level view: position within the current period, a stop request
    // that finishes at the end of the period, and a pending ratio for the next one.
    task automatic model_step();
        if (!m_on) begin
            if (LOAD) m_n = clampn(int'(DIV));
            if (EN) begin m_on = 1; m_pos = 0; m_stop = 0; end
        end else if (m_pos == m_n - 1) begin
            if (LOAD) m_n = clampn(int'(DIV));
            else if (m_pend >= 0) m_n = m_pend;
            m_pend = -1;
            m_pos = 0;
            if (m_stop && !EN) m_on = 0;
            m_stop = !EN;
        end else begin
            m_pos++;
            if (LOAD) m_pend = clampn(int'(DIV));
            m_stop = !EN;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_O"}, 32'(O), 32'(m_on && (m_pos < m_n / 2)));
        chk({tag, "_ACTIVE"}, 32'(ACTIVE), 32'(m_on));
        chk({tag, "_BUSY"}, 32'(BUSY), 32'(m_pend >= 0));
    endtask

    task automatic step(input string tag, input bit en, input bit ld, input int dv);
        EN = en; LOAD = ld; DIV = 8'(dv);
        @(posedge C);
        model_step();
        #1;
        check_all(tag);
    endtask

    bit ren;

    initial begin
        model_reset();
        #1;
        chk("rst_O", 32'(O), 0);
        chk("rst_ACTIVE", 32'(ACTIVE), 0);
        chk("rst_BUSY", 32'(BUSY), 0);
        repeat (2) @(posedge C);
        #1 R = 1'b1;
        for (int i = 0; i < 6; i++) step("div2", 1, 0, 0);
        for (int i = 0; i < 4; i++) step("stop2", 0, 0, 0);

        step("load5_idle", 0, 1, 5);
        for (int i = 0; i < 12; i++) step("run5", 1, 0, 0);
        for (int i = 0; i < 8; i++) step("stop5", 0, 0, 0);

        step("load4", 0, 1, 4);
        step("run4", 1, 0, 0);
        step("run4", 1, 0, 0);
        step("load6_cnt1", 1, 1, 6);
        for (int i = 0; i < 14; i++) step("run6", 1, 0, 0);
        for (int i = 0; i < 8; i++) step("stop6", 0, 0, 0);

        step("load8", 0, 1, 8);
        for (int i = 0; i < 3; i++) step("run8", 1, 0, 0);
        for (int i = 0; i < 9; i++) step("stop8", 0, 0, 0);

        step("load0", 0, 1, 0);
        for (int i = 0; i < 5; i++) step("run_d0", 1, 0, 0);
        step("load1", 1, 1, 1);
        for (int i = 0; i < 5; i++) step("run_d1", 1, 0, 0);
        step("load3", 1, 1, 3);
        step("load7", 1, 1, 7);
        for (int i = 0; i < 16; i++) step("run7", 1, 0, 0);
        for (int i = 0; i < 8; i++) step("stop7", 0, 0, 0);

        step("load10", 0, 1, 10);
        step("run10", 1, 0, 0);
        step("run10", 1, 0, 0);
        chk("pre_rst_O", 32'(O), 1);
        R = 1'b0;
        #2;
        model_reset();
        chk("async_rst_O", 32'(O), 0);
        chk("async_rst_ACTIVE", 32'(ACTIVE), 0);
        chk("async_rst_BUSY", 32'(BUSY), 0);
        @(posedge C);
        #1 R = 1'b1;
        for (int i = 0; i < 6; i++) step("post_rst", 1, 0, 0);

        ren = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) ren = !ren;
            step("rand", ren, $urandom_range(0, 6) == 0, int'($urandom_range(0, 13)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
